// File: rtl/pto_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module   : pto_ramp_gen
// Brief    : Pulse-train output generator with linear period ramps (accel,
//            cruise, decel) timed in microsecond ticks. Define
//            PTO_SOFT_STOP_EN to turn abort into a ramped stop.
// Revision : 1.0  initial release
// ============================================================================
module pto_ramp_gen #(
    parameter int CNT_W      = 32,
    parameter int PER_W      = 16,
    parameter int CLK_PER_US = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_total,
    input  logic [CNT_W-1:0] accel_pulses,
    input  logic [CNT_W-1:0] decel_pulses,
    input  logic [PER_W-1:0] period_max_us,
    input  logic [PER_W-1:0] period_min_us,
    input  logic [PER_W-1:0] step_us,
    input  logic             dir_in,
    output logic             pto_out,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_count,
    output logic [PER_W-1:0] period_us
);

    localparam int                c_PS_W      = $clog2(CLK_PER_US);
    localparam logic [c_PS_W-1:0] c_PS_LAST   = c_PS_W'(CLK_PER_US - 1);
    localparam logic [PER_W-1:0]  c_PER_FLOOR = PER_W'(2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEL  = 2'd1,
        S_CRUISE = 2'd2,
        S_DECEL  = 2'd3
    } state_t;

    // Decel wins over accel when the two ramp regions overlap.
    function automatic state_t phase_of(input logic [CNT_W-1:0] c,
                                        input logic [CNT_W-1:0] acc,
                                        input logic [CNT_W-1:0] dstart);
        if (c >= dstart)   return S_DECEL;
        else if (c < acc)  return S_ACCEL;
        else               return S_CRUISE;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_total, r_accel, r_dstart, r_count;
    logic [PER_W-1:0]   r_pmax, r_pmin, r_step, r_period, r_ticks;
    logic [c_PS_W-1:0]  r_presc;
    logic               r_dir, r_pto, r_done;

    logic [CNT_W-1:0]   w_total_nxt, w_accel_nxt, w_dstart_nxt, w_count_nxt, w_cnt_inc, w_dstart_in;
    logic [PER_W-1:0]   w_pmax_nxt, w_pmin_nxt, w_step_nxt, w_period_nxt, w_ticks_nxt;
    logic [PER_W-1:0]   w_ticks_inc, w_per_up, w_per_dn, w_max_cl, w_min_lo, w_min_cl;
    logic [c_PS_W-1:0]  w_presc_nxt;
    logic               w_dir_nxt, w_pto_nxt, w_done_nxt, w_tick, w_pulse_end;
    logic               w_hard_abort, w_soft_stop;

`ifdef PTO_SOFT_STOP_EN
    logic r_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_stop <= 1'b0;
        else if (r_state == S_IDLE) r_stop <= 1'b0;
        else if (abort)             r_stop <= 1'b1;
    end

    always_comb begin
        w_hard_abort = 1'b0;
        w_soft_stop  = r_stop | abort;
    end
`else
    always_comb begin
        w_hard_abort = abort;
        w_soft_stop  = 1'b0;
    end
`endif

    always_comb begin
        w_tick      = (r_presc == c_PS_LAST);
        w_ticks_inc = r_ticks + PER_W'(1);
        w_cnt_inc   = r_count + CNT_W'(1);
        w_pulse_end = w_tick && (w_ticks_inc == r_period);
        w_per_up    = (r_step >= (r_pmax - r_period)) ? r_pmax : (r_period + r_step);
        w_per_dn    = (r_step >= (r_period - r_pmin)) ? r_pmin : (r_period - r_step);
        w_max_cl    = (period_max_us < c_PER_FLOOR) ? c_PER_FLOOR : period_max_us;
        w_min_lo    = (period_min_us < c_PER_FLOOR) ? c_PER_FLOOR : period_min_us;
        w_min_cl    = (w_min_lo > w_max_cl) ? w_max_cl : w_min_lo;
        w_dstart_in = (decel_pulses >= pulse_total) ? '0 : (pulse_total - decel_pulses);

        w_state_nxt  = r_state;
        w_total_nxt  = r_total;
        w_accel_nxt  = r_accel;
        w_dstart_nxt = r_dstart;
        w_pmax_nxt   = r_pmax;
        w_pmin_nxt   = r_pmin;
        w_step_nxt   = r_step;
        w_dir_nxt    = r_dir;
        w_count_nxt  = r_count;
        w_period_nxt = r_period;
        w_ticks_nxt  = r_ticks;
        w_presc_nxt  = r_presc;
        w_pto_nxt    = r_pto;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_total_nxt  = pulse_total;
                    w_accel_nxt  = accel_pulses;
                    w_dstart_nxt = w_dstart_in;
                    w_pmax_nxt   = w_max_cl;
                    w_pmin_nxt   = w_min_cl;
                    w_step_nxt   = step_us;
                    w_dir_nxt    = dir_in;
                    w_count_nxt  = '0;
                    w_period_nxt = w_max_cl;
                    w_ticks_nxt  = '0;
                    w_presc_nxt  = '0;
                    w_pto_nxt    = 1'b0;
                    w_state_nxt  = phase_of('0, accel_pulses, w_dstart_in);
                end
            end
            default: begin
                // Only reachable with a zero-length move: finish without pulsing.
                if (r_count == r_total) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_hard_abort) begin
                    w_state_nxt = S_IDLE;
                    w_pto_nxt   = 1'b0;
                end else begin
                    w_presc_nxt = w_tick ? '0 : (r_presc + c_PS_W'(1));
                    if (w_pulse_end) begin
                        w_count_nxt = w_cnt_inc;
                        w_ticks_nxt = '0;
                        w_pto_nxt   = 1'b0;
                        if (w_cnt_inc == r_total) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else if (w_soft_stop) begin
                            if (r_period == r_pmax) begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_period_nxt = w_per_up;
                                w_state_nxt  = S_DECEL;
                            end
                        end else begin
                            w_state_nxt = phase_of(w_cnt_inc, r_accel, r_dstart);
                            if (w_cnt_inc >= r_dstart)     w_period_nxt = w_per_up;
                            else if (w_cnt_inc <= r_accel) w_period_nxt = w_per_dn;
                        end
                    end else if (w_tick) begin
                        w_ticks_nxt = w_ticks_inc;
                        if (w_ticks_inc == (r_period >> 1)) w_pto_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_total  <= '0;
            r_accel  <= '0;
            r_dstart <= '0;
            r_pmax   <= '0;
            r_pmin   <= '0;
            r_step   <= '0;
            r_dir    <= 1'b0;
            r_count  <= '0;
            r_period <= '0;
            r_ticks  <= '0;
            r_presc  <= '0;
            r_pto    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_total  <= w_total_nxt;
            r_accel  <= w_accel_nxt;
            r_dstart <= w_dstart_nxt;
            r_pmax   <= w_pmax_nxt;
            r_pmin   <= w_pmin_nxt;
            r_step   <= w_step_nxt;
            r_dir    <= w_dir_nxt;
            r_count  <= w_count_nxt;
            r_period <= w_period_nxt;
            r_ticks  <= w_ticks_nxt;
            r_presc  <= w_presc_nxt;
            r_pto    <= w_pto_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign pto_out     = r_pto;
    assign dir_out     = r_dir;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign pulse_count = r_count;
    assign period_us   = r_period;

endmodule
`default_nettype wire

// File: doc/pto_ramp_gen.md
PTO_RAMP_GEN -- requirements
Module: pto_ramp_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of pulse counts.
REQ-002 SHALL have parameter PER_W, default 16, width of period/step values in microseconds.
REQ-003 SHALL have parameter CLK_PER_US, default 50, clk cycles per microsecond tick (>=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  move request, sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  stop request, level-sampled while busy.
REQ-008 SHALL have ports pulse_total, accel_pulses, decel_pulses  input  CNT_W each  move length and ramp lengths.
REQ-009 SHALL have ports period_max_us, period_min_us, step_us  input  PER_W each  start/stop period, cruise period, ramp step.
REQ-010 SHALL have port dir_in  input  1  requested direction.
REQ-011 SHALL have outputs pto_out 1, dir_out 1, busy 1, done 1 (one-cycle strobe), pulse_count CNT_W, period_us PER_W (period of pulse in progress).

Function
REQ-012 SHALL implement states IDLE, ACCEL, CRUISE, DECEL; busy=1 in all states except IDLE.
REQ-013 SHALL, on start=1 in IDLE, latch all config inputs and dir_in, clear pulse_count and prescaler, load period_us=period_max_us; later input changes ignored until next IDLE.
REQ-014 SHALL clamp at latch: period_min_us>period_max_us -> min=max; any period <2 -> 2; step_us=0 -> constant period.
REQ-015 SHALL generate us tick when prescaler reaches CLK_PER_US-1, then wrap to 0.
REQ-016 SHALL shape each pulse of period P: pto_out=0 for first floor(P/2) ticks, 1 for remaining ticks; pulse ends on Pth tick with pto_out->0 and pulse_count+1.
REQ-017 SHALL, at end of each pulse with new count c: c<=accel_pulses -> P=max(P-step,min); c>=pulse_total-decel_pulses -> P=min(P+step,max); else unchanged; decel rule wins on overlap.
REQ-018 SHALL report state: ACCEL while c<accel_pulses, DECEL while c>=pulse_total-decel_pulses, CRUISE otherwise.
REQ-019 SHALL, when c==pulse_total, return to IDLE and pulse done=1 for exactly one cycle on same edge; pulse_count holds final value.
REQ-020 SHALL, for pulse_total=0, go IDLE and strobe done the cycle after start with no pulses.
REQ-021 SHALL ignore start while busy; start and abort together in IDLE: start wins.
REQ-022 SHALL drive dir_out from latched direction, stable for whole move.
REQ-023 SHALL use CNT_W/PER_W arithmetic with saturation, no wrap (pulse_total-decel_pulses floors at 0).

Reset
REQ-024 SHALL, on rst=0, immediately set state IDLE, pto_out=0, dir_out=0, busy=0, done=0, pulse_count=0, period_us=0, prescaler 0, mid-pulse included.
REQ-025 SHALL resume on first clk edge after rst deasserts, waiting for start.

Configuration
REQ-026 SHALL support macro PTO_SOFT_STOP_EN.
REQ-027 SHALL, with PTO_SOFT_STOP_EN defined, on abort while busy, finish current pulse, enter DECEL, step period up per pulse until period_max_us pulse completes, then IDLE with done strobe.
REQ-028 SHALL, without PTO_SOFT_STOP_EN, on abort while busy, go IDLE next edge with pto_out=0, no done strobe, pulse_count holding pulses completed.

Verification
REQ-029 SHALL test CLK_PER_US=2, total=10, accel=3, decel=3, max=10, min=4, step=2 -> periods 10,8,6,4,4,4,4,6,8,10 us, 10 pulses, done at cycle 128 after start.
REQ-030 SHALL test pulse_total=0 -> no pto_out edge, done one cycle after start, busy 1 for exactly one cycle.
REQ-031 SHALL test accel=8, decel=8, total=10 -> decel rule wins at c>=2, period never below max-step*2.
REQ-032 SHALL test abort at pulse 4 of REQ-029 profile -> with macro: pulses 6,8,10 then done; without: pto_out=0 next edge, pulse_count=4, no done.
REQ-033 SHALL test rst low mid-high-phase -> pto_out=0 without clock edge, all outputs at reset values.
REQ-034 SHALL test start re-asserted mid-move and min=12>max=10 -> start ignored; constant 10 us period.
